// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and memory stage (ME).
// ME has priority; IF is forced through after MAX_WAIT consecutive denied cycles.
module mem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              me_req_i,
  input  logic              me_we_i,
  input  logic [ADDR_W-1:0] me_addr_i,
  input  logic [DATA_W-1:0] me_wdata_i,
  output logic              me_gnt_o,
  output logic              me_rvalid_o,
  output logic [DATA_W-1:0] me_rdata_o,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              stall_me_o,
  output logic              stall_if_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              me_rvalid_q, me_rvalid_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] me_rdata_q, me_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              force_if_s;
  logic              me_gnt_s;
  logic              if_gnt_s;

  always_comb begin
    force_if_s = (wait_cnt_q == MAX_CNT);
    me_gnt_s   = 1'b0;
    if_gnt_s   = 1'b0;
    if (reset) begin
      me_gnt_s = 1'b0;
      if_gnt_s = 1'b0;
    end else if (me_req_i && !(if_req_i && force_if_s)) begin
      me_gnt_s = 1'b1;
    end else if (if_req_i) begin
      if_gnt_s = 1'b1;
    end else begin
      me_gnt_s = 1'b0;
      if_gnt_s = 1'b0;
    end
  end

  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    if (me_gnt_s) begin
      ram_addr_o  = me_addr_i;
      ram_wdata_o = me_wdata_i;
      ram_we_o    = me_we_i;
    end else if (if_gnt_s) begin
      ram_addr_o  = if_addr_i;
      ram_wdata_o = '0;
      ram_we_o    = 1'b0;
    end else begin
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      ram_we_o    = 1'b0;
    end
  end

  // Starvation counter saturates at MAX_WAIT; rdata holds unless a read is captured.
  always_comb begin
    wait_cnt_d = '0;
    if (if_req_i && !if_gnt_s) begin
      wait_cnt_d = force_if_s ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
    me_rvalid_d = me_gnt_s && !me_we_i;
    if_rvalid_d = if_gnt_s;
    me_rdata_d  = me_rvalid_d ? ram_rdata_i : me_rdata_q;
    if_rdata_d  = if_rvalid_d ? ram_rdata_i : if_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      me_rvalid_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      me_rdata_q  <= '0;
      if_rdata_q  <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      me_rvalid_q <= me_rvalid_d;
      if_rvalid_q <= if_rvalid_d;
      me_rdata_q  <= me_rdata_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

  assign me_gnt_o    = me_gnt_s;
  assign if_gnt_o    = if_gnt_s;
  assign stall_me_o  = me_req_i && !me_gnt_s;
  assign stall_if_o  = if_req_i && !if_gnt_s;
  assign me_rvalid_o = me_rvalid_q;
  assign me_rdata_o  = me_rdata_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;

endmodule
